// File: rtl/l1d_bank_issue_scheduler.sv
// In-order L1D request queue that issues up to ISSUE_WIDTH head entries per cycle
// to BANK_COUNT bank ports, each entry choosing its lowest-index free, ready, enabled bank.
module l1d_bank_issue_scheduler #(
  parameter int unsigned ENQ_WIDTH   = 2,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned BANK_COUNT  = 4,
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned TAG_WIDTH   = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ENQ_WIDTH-1:0]              enq_vld_i,
  input  logic [ENQ_WIDTH*BANK_COUNT-1:0]   enq_bank_en_i,
  input  logic [ENQ_WIDTH*TAG_WIDTH-1:0]    enq_tag_i,
  output logic                              enq_rdy_o,
  input  logic                              flush_i,
  input  logic [BANK_COUNT-1:0]             bank_rdy_i,
  output logic [BANK_COUNT-1:0]             bank_vld_o,
  output logic [BANK_COUNT*TAG_WIDTH-1:0]   bank_tag_o,
  output logic [$clog2(ISSUE_WIDTH+1)-1:0]  deq_cnt_o,
  output logic [$clog2(DEPTH+1)-1:0]        occupancy_o,
  output logic                              empty_o,
  output logic                              full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned DW = $clog2(ISSUE_WIDTH + 1);

  logic [PW-1:0]         head_q, tail_q;
  logic [CW-1:0]         count_q;
  logic [BANK_COUNT-1:0] ent_en_q  [DEPTH];
  logic [TAG_WIDTH-1:0]  ent_tag_q [DEPTH];

  logic                  accept;
  logic [ENQ_WIDTH-1:0]  lane_we;
  logic [PW-1:0]         lane_idx [ENQ_WIDTH];
  logic [CW-1:0]         enq_cnt;

  logic [BANK_COUNT-1:0] taken, avail, sel;
  logic                  chain;
  logic [PW-1:0]         slot_idx;
  logic [DW-1:0]         deq_cnt;

  // Credit comes from the registered count only; a same-cycle pop does not help.
  assign enq_rdy_o   = (count_q <= CW'(DEPTH - ENQ_WIDTH));
  assign occupancy_o = count_q;
  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CW'(DEPTH));
  assign deq_cnt_o   = deq_cnt;

  // Compact valid lanes into consecutive slots starting at the tail.
  always_comb begin
    accept  = enq_rdy_o && !flush_i && !rst;
    enq_cnt = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      lane_we[i]  = accept && enq_vld_i[i];
      lane_idx[i] = tail_q + PW'(enq_cnt);
      if (lane_we[i]) enq_cnt = enq_cnt + CW'(1);
    end
  end

  // Slot k only issues if every older slot issued; successes form a prefix.
  always_comb begin
    taken      = '0;
    avail      = '0;
    sel        = '0;
    slot_idx   = '0;
    deq_cnt    = '0;
    bank_tag_o = '0;
    chain      = !flush_i && !rst;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      slot_idx = head_q + PW'(k);
      avail    = ent_en_q[slot_idx] & bank_rdy_i & ~taken;
      sel      = avail & (~avail + BANK_COUNT'(1));
      if (chain && (CW'(k) < count_q) && (avail != '0)) begin
        taken   = taken | sel;
        deq_cnt = deq_cnt + DW'(1);
        for (int b = 0; b < BANK_COUNT; b++) begin
          if (sel[b]) bank_tag_o[b*TAG_WIDTH +: TAG_WIDTH] = ent_tag_q[slot_idx];
        end
      end else begin
        chain = 1'b0;
      end
    end
    bank_vld_o = taken;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PW'(deq_cnt);
      tail_q  <= tail_q + PW'(enq_cnt);
      count_q <= count_q + enq_cnt - CW'(deq_cnt);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      if (lane_we[i]) begin
        ent_en_q[lane_idx[i]]  <= enq_bank_en_i[i*BANK_COUNT +: BANK_COUNT];
        ent_tag_q[lane_idx[i]] <= enq_tag_i[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_l1d_bank_issue_scheduler.sv
// Directed, table-driven bench for l1d_bank_issue_scheduler with the default parameters;
// each vector is one cycle of inputs plus the outputs expected before the next edge.
module tb_l1d_bank_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  enq_vld_i;
  logic [7:0]  enq_bank_en_i;
  logic [15:0] enq_tag_i;
  logic        enq_rdy_o;
  logic        flush_i;
  logic [3:0]  bank_rdy_i;
  logic [3:0]  bank_vld_o;
  logic [31:0] bank_tag_o;
  logic [1:0]  deq_cnt_o;
  logic [3:0]  occupancy_o;
  logic        empty_o;
  logic        full_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l1d_bank_issue_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .enq_vld_i    (enq_vld_i),
    .enq_bank_en_i(enq_bank_en_i),
    .enq_tag_i    (enq_tag_i),
    .enq_rdy_o    (enq_rdy_o),
    .flush_i      (flush_i),
    .bank_rdy_i   (bank_rdy_i),
    .bank_vld_o   (bank_vld_o),
    .bank_tag_o   (bank_tag_o),
    .deq_cnt_o    (deq_cnt_o),
    .occupancy_o  (occupancy_o),
    .empty_o      (empty_o),
    .full_o       (full_o)
  );

  // An accepted request with no enabled bank would wedge the queue.
  always @(posedge clk) begin
    if (!rst && !flush_i && enq_rdy_o) begin
      if (enq_vld_i[0]) assert (enq_bank_en_i[3:0] != 4'b0) else $error("zero bank_en lane0");
      if (enq_vld_i[1]) assert (enq_bank_en_i[7:4] != 4'b0) else $error("zero bank_en lane1");
    end
  end

  typedef struct {
    logic        rst;
    logic        flush;
    logic [1:0]  vld;
    logic [7:0]  en;
    logic [15:0] tag;
    logic [3:0]  rdy;
    logic [3:0]  e_vld;
    logic [31:0] e_tag;
    logic [1:0]  e_deq;
    logic [3:0]  e_occ;
    logic        e_empty;
    logic        e_full;
    logic        e_enq_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic f, logic [1:0] v, logic [7:0] en,
                              logic [15:0] tg, logic [3:0] rd, logic [3:0] ev,
                              logic [31:0] et, logic [1:0] ed, logic [3:0] eo,
                              logic ee, logic ef, logic er);
    vec_t x;
    x.rst = r; x.flush = f; x.vld = v; x.en = en; x.tag = tg; x.rdy = rd;
    x.e_vld = ev; x.e_tag = et; x.e_deq = ed; x.e_occ = eo;
    x.e_empty = ee; x.e_full = ef; x.e_enq_rdy = er;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic [1:0] v,
                       input logic [7:0] en, input logic [15:0] tg, input logic [3:0] rd);
    rst = r; flush_i = f; enq_vld_i = v; enq_bank_en_i = en; enq_tag_i = tg; bank_rdy_i = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 2'b00, 8'h00, 16'h0000, 4'hF);
    step();

    // Reset held with all banks ready
    vecs.push_back(mk(1,0,2'b00,8'h00,16'h0000,4'hF, 4'h0,32'h0,0,0,1,0,1));
    vecs.push_back(mk(1,0,2'b11,8'h11,16'h0505,4'hF, 4'h0,32'h0,0,0,1,0,1));
    // Single entry, no bypass, then issue on bank2
    vecs.push_back(mk(0,0,2'b01,8'h04,16'h0011,4'hF, 4'h0,32'h0,0,0,1,0,1));
    vecs.push_back(mk(0,0,2'b00,8'h00,16'h0000,4'hF, 4'h4,32'h0011_0000,1,1,0,0,1));
    vecs.push_back(mk(0,0,2'b00,8'h00,16'h0000,4'hF, 4'h0,32'h0,0,0,1,0,1));
    // A{0011} takes bank0, B{0001} loses bank0 this cycle, issues next
    vecs.push_back(mk(0,0,2'b11,8'h13,16'h0201,4'hF, 4'h0,32'h0,0,0,1,0,1));
    vecs.push_back(mk(0,0,2'b00,8'h00,16'h0000,4'hF, 4'h1,32'h0000_0001,1,2,0,0,1));
    vecs.push_back(mk(0,0,2'b00,8'h00,16'h0000,4'hF, 4'h1,32'h0000_0002,1,1,0,0,1));
    vecs.push_back(mk(0,0,2'b00,8'h00,16'h0000,4'hF, 4'h0,32'h0,0,0,1,0,1));
    // In-order block: A{0010} stalls, B{0001} must not pass it
    vecs.push_back(mk(0,0,2'b11,8'h12,16'h0403,4'h1, 4'h0,32'h0,0,0,1,0,1));
    vecs.push_back(mk(0,0,2'b00,8'h00,16'h0000,4'h1, 4'h0,32'h0,0,2,0,0,1));
    vecs.push_back(mk(0,0,2'b00,8'h00,16'h0000,4'hF, 4'h3,32'h0000_0304,2,2,0,0,1));
    // Fill to 8 with banks stalled, crossing the pointer wrap; 5th group dropped
    vecs.push_back(mk(0,0,2'b11,8'h21,16'h2120,4'h0, 4'h0,32'h0,0,0,1,0,1));
    vecs.push_back(mk(0,0,2'b11,8'h21,16'h2322,4'h0, 4'h0,32'h0,0,2,0,0,1));
    vecs.push_back(mk(0,0,2'b11,8'h21,16'h2524,4'h0, 4'h0,32'h0,0,4,0,0,1));
    vecs.push_back(mk(0,0,2'b11,8'h21,16'h2726,4'h0, 4'h0,32'h0,0,6,0,0,1));
    vecs.push_back(mk(0,0,2'b11,8'h21,16'h2928,4'h0, 4'h0,32'h0,0,8,0,1,0));
    vecs.push_back(mk(0,0,2'b00,8'h00,16'h0000,4'h0, 4'h0,32'h0,0,8,0,1,0));
    // Drain in order, dual issue when banks allow
    vecs.push_back(mk(0,0,2'b00,8'h00,16'h0000,4'hF, 4'h3,32'h0000_2120,2,8,0,1,0));
    vecs.push_back(mk(0,0,2'b00,8'h00,16'h0000,4'hF, 4'h3,32'h0000_2322,2,6,0,0,1));
    vecs.push_back(mk(0,0,2'b00,8'h00,16'h0000,4'h1, 4'h1,32'h0000_0024,1,4,0,0,1));
    vecs.push_back(mk(0,0,2'b00,8'h00,16'h0000,4'h2, 4'h2,32'h0000_2500,1,3,0,0,1));
    vecs.push_back(mk(0,0,2'b10,8'h40,16'h3000,4'hF, 4'h3,32'h0000_2726,2,2,0,0,1));
    vecs.push_back(mk(0,0,2'b11,8'h11,16'h3231,4'h0, 4'h0,32'h0,0,1,0,0,1));
    // Flush with 3 queued: no issue that cycle, empty after
    vecs.push_back(mk(0,1,2'b01,8'h02,16'h0033,4'hF, 4'h0,32'h0,0,3,0,0,1));
    vecs.push_back(mk(0,0,2'b00,8'h00,16'h0000,4'hF, 4'h0,32'h0,0,0,1,0,1));
    // enq_rdy drops at occupancy 7; lane1-only group there is dropped
    vecs.push_back(mk(0,0,2'b11,8'h11,16'h4140,4'h0, 4'h0,32'h0,0,0,1,0,1));
    vecs.push_back(mk(0,0,2'b11,8'h11,16'h4342,4'h0, 4'h0,32'h0,0,2,0,0,1));
    vecs.push_back(mk(0,0,2'b11,8'h11,16'h4544,4'h0, 4'h0,32'h0,0,4,0,0,1));
    vecs.push_back(mk(0,0,2'b01,8'h01,16'h0046,4'h0, 4'h0,32'h0,0,6,0,0,1));
    vecs.push_back(mk(0,0,2'b10,8'h10,16'h4700,4'h0, 4'h0,32'h0,0,7,0,0,0));
    vecs.push_back(mk(0,0,2'b00,8'h00,16'h0000,4'hF, 4'h1,32'h0000_0040,1,7,0,0,0));
    // Reset mid-operation discards entries
    vecs.push_back(mk(1,0,2'b00,8'h00,16'h0000,4'hF, 4'h0,32'h0,0,6,0,0,1));
    vecs.push_back(mk(0,0,2'b00,8'h00,16'h0000,4'hF, 4'h0,32'h0,0,0,1,0,1));
    vecs.push_back(mk(0,0,2'b01,8'h08,16'h0055,4'hF, 4'h0,32'h0,0,0,1,0,1));
    vecs.push_back(mk(0,0,2'b00,8'h00,16'h0000,4'hF, 4'h8,32'h5500_0000,1,1,0,0,1));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].vld, vecs[i].en, vecs[i].tag, vecs[i].rdy);
      #1;
      check($sformatf("v%0d bank_vld", i), 32'(bank_vld_o), 32'(vecs[i].e_vld));
      check($sformatf("v%0d bank_tag", i), bank_tag_o, vecs[i].e_tag);
      check($sformatf("v%0d deq_cnt", i), 32'(deq_cnt_o), 32'(vecs[i].e_deq));
      check($sformatf("v%0d occupancy", i), 32'(occupancy_o), 32'(vecs[i].e_occ));
      check($sformatf("v%0d empty", i), 32'(empty_o), 32'(vecs[i].e_empty));
      check($sformatf("v%0d full", i), 32'(full_o), 32'(vecs[i].e_full));
      check($sformatf("v%0d enq_rdy", i), 32'(enq_rdy_o), 32'(vecs[i].e_enq_rdy));
      step();
    end

    // rst and flush together with entries queued and banks stalled
    drive(1'b0, 1'b0, 2'b11, 8'h84, 16'h6160, 4'h0);
    step();
    drive(1'b1, 1'b1, 2'b00, 8'h00, 16'h0000, 4'hF);
    #1;
    check("rstflush occ_before", 32'(occupancy_o), 32'd2);
    check("rstflush bank_vld", 32'(bank_vld_o), 32'd0);
    step();
    drive(1'b0, 1'b0, 2'b00, 8'h00, 16'h0000, 4'hF);
    #1;
    check("rstflush occ_after", 32'(occupancy_o), 32'd0);
    check("rstflush empty", 32'(empty_o), 32'd1);
    check("rstflush bank_vld_after", 32'(bank_vld_o), 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
